// File: rtl/modport_slave.sv
// 256x16 register-file slave: stores on write cycles, returns registered read data one cycle later.
// Optional even-parity storage and error flag are built when MODPORT_PARITY_EN is defined.
module modport_slave #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 1 << ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              write,
   input  logic [DATA_W-1:0] data_in,
   input  logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] data_out,
   output logic              par_err
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Read data only moves on read cycles; a write leaves the last read value visible.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         data_out <= '0;
      end else if (write) begin
         mem[address] <= data_in;
      end else begin
         data_out <= mem[address];
      end
   end

`ifdef MODPORT_PARITY_EN
   // Kept as a packed vector apart from the data words so a single parity bit can be corrupted on its own.
   logic [DEPTH-1:0] par_mem;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_mem <= '0;
         par_err <= 1'b0;
      end else if (write) begin
         par_mem[address] <= ^data_in;
         par_err          <= 1'b0;
      end else begin
         par_err <= par_mem[address] ^ (^mem[address]);
      end
   end
`else
   assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_modport_slave.sv
// Bench for modport_slave: directed scenarios plus random traffic against an array-based reference model.
module tb_modport_slave;

   logic        clk;
   logic        rst_n;
   logic        write;
   logic [15:0] data_in;
   logic [7:0]  address;
   logic [15:0] data_out;
   logic        par_err;

   int n_assert = 0;
   int n_fail   = 0;

   logic [15:0] model_mem [256];
   logic [15:0] model_out;

   modport_slave dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .write    (write),
      .data_in  (data_in),
      .address  (address),
      .data_out (data_out),
      .par_err  (par_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 256; i++) model_mem[i] = 16'h0000;
      model_out = 16'h0000;
   endtask

   // Drive one bus cycle at the negedge, let the posedge sample it, then check just after the edge.
   task automatic cycle(input logic w, input logic [7:0] a, input logic [15:0] d, input string tag);
      @(negedge clk);
      write   = w;
      address = a;
      data_in = d;
      @(posedge clk);
      if (w) model_mem[a] = d;
      else   model_out = model_mem[a];
      #1;
      chk(tag, data_out, model_out);
      chk({tag, "_par"}, {15'd0, par_err}, 16'h0000);
   endtask

   initial begin
      logic [7:0]  a;
      logic [15:0] d;
      logic        w;

      rst_n   = 1'b0;
      write   = 1'b0;
      address = 8'h00;
      data_in = 16'h0000;
      model_clear();

      // 1: reset state, then read after release
      repeat (3) @(posedge clk);
      #1;
      chk("reset_data_out", data_out, 16'h0000);
      chk("reset_par_err", {15'd0, par_err}, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1'b0, 8'h7C, 16'h0000, "read_after_reset");

      // 2: write then read same address
      cycle(1'b1, 8'h10, 16'hA5A5, "wr_10");
      cycle(1'b0, 8'h10, 16'h0000, "rd_10");
      chk("rd_10_const", data_out, 16'hA5A5);

      // 3: both ends of the address range, back-to-back reads
      cycle(1'b1, 8'h00, 16'h0001, "wr_00");
      cycle(1'b1, 8'hFF, 16'hFFFF, "wr_ff");
      cycle(1'b0, 8'h00, 16'h0000, "rd_00");
      chk("rd_00_const", data_out, 16'h0001);
      cycle(1'b0, 8'hFF, 16'h0000, "rd_ff");
      chk("rd_ff_const", data_out, 16'hFFFF);

      // 4: data_out holds across a write cycle
      cycle(1'b0, 8'h10, 16'h0000, "rd_10_again");
      cycle(1'b1, 8'h20, 16'h1234, "wr_20_hold");
      chk("hold_during_write", data_out, 16'hA5A5);
      cycle(1'b0, 8'h20, 16'h0000, "rd_20");
      chk("rd_20_const", data_out, 16'h1234);

      // 5: async reset between posedges clears memory and data_out at once
      cycle(1'b1, 8'h33, 16'hBEEF, "wr_33");
      cycle(1'b0, 8'h33, 16'h0000, "rd_33");
      chk("rd_33_const", data_out, 16'hBEEF);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_clear_out", data_out, 16'h0000);
      // a write presented while reset is held is lost
      @(negedge clk);
      write   = 1'b1;
      address = 8'h44;
      data_in = 16'h5555;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      model_clear();
      cycle(1'b0, 8'h33, 16'h0000, "rd_33_after_rst");
      cycle(1'b0, 8'h44, 16'h0000, "rd_44_lost_write");
      cycle(1'b0, 8'h10, 16'h0000, "rd_10_after_rst");

`ifdef MODPORT_PARITY_EN
      // 6: corrupt one stored parity bit and expect the flag on read
      begin
         logic [255:0] par_img;
         cycle(1'b1, 8'h40, 16'h0F0F, "wr_40");
         par_img = dut.par_mem;
         par_img[8'h40] = ~par_img[8'h40];
         force dut.par_mem = par_img;
         @(negedge clk);
         write   = 1'b0;
         address = 8'h40;
         @(posedge clk);
         #1;
         model_out = 16'h0F0F;
         chk("par_rd_40_data", data_out, 16'h0F0F);
         chk("par_rd_40_err", {15'd0, par_err}, 16'h0001);
         @(negedge clk);
         address = 8'h41;
         @(posedge clk);
         #1;
         model_out = 16'h0000;
         chk("par_rd_41_data", data_out, 16'h0000);
         chk("par_rd_41_err", {15'd0, par_err}, 16'h0000);
         release dut.par_mem;
         // restore a clean image via reset
         @(negedge clk);
         rst_n = 1'b0;
         @(negedge clk);
         rst_n = 1'b1;
         model_clear();
      end
`endif

      // random traffic, biased to a small address pool for frequent hits
      for (int i = 0; i < 400; i++) begin
         w = ($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 3) == 0) a = 8'($urandom_range(0, 255));
         else                           a = 8'($urandom_range(0, 7)) | 8'hF8 & 8'($urandom_range(0, 1) * 255);
         d = 16'($urandom);
         cycle(w, a, d, "random");
      end

      // sweep-read every word against the model
      for (int i = 0; i < 256; i++) begin
         cycle(1'b0, 8'(i), 16'h0000, "sweep");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
